// File: rtl/memoria_buffer.sv
// -----------------------------------------------------------------------------
// memoria_buffer
//
// Block-RAM buffer placed between a word source (UART, header loader, ...) and
// the hashing core. A complete block is written in (FILL) and then read out as
// many times as needed (DRAIN). The buffer keeps its own write and read
// pointers. Each side uses a valid/ready stream.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   start_fill     pulse: clear pointers and flags, enter FILL (any state)
//   start_drain    pulse: rewind read pointer, enter DRAIN (only from FULL)
//   in_valid       write word offered
//   in_data        write word
//   in_last        marks in_data as the final word of the fill
//   in_ready       buffer accepts a write word (high only in FILL)
//   out_valid      out_data holds a valid word
//   out_data       read word (registered RAM output)
//   out_ready      consumer accepts out_data
//   fill_count     words stored by the last fill (0..DEPTH)
//   state          00 IDLE, 01 FILL, 10 FULL, 11 DRAIN
//   fine_scrittura sticky: the fill has completed
//   fine_lettura   sticky: the drain has completed
// -----------------------------------------------------------------------------
module memoria_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 512
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_fill,
    input  logic                    start_drain,
    input  logic                    in_valid,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [DATA_WIDTH-1:0]   out_data,
    input  logic                    out_ready,
    output logic [$clog2(DEPTH):0]  fill_count,
    output logic [1:0]              state,
    output logic                    fine_scrittura,
    output logic                    fine_lettura
);

    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int CNT_WIDTH  = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FILL  = 2'b01,
        ST_FULL  = 2'b10,
        ST_DRAIN = 2'b11
    } state_t;

    // Storage. Not reset, so it maps onto block RAM.
    logic [DATA_WIDTH-1:0] ram [0:DEPTH-1];

    state_t                 state_q,          state_d;
    logic [ADDR_WIDTH-1:0]  wr_ptr_q,         wr_ptr_d;
    // The read pointer has one extra bit so it can reach fill_count (up to DEPTH).
    logic [CNT_WIDTH-1:0]   rd_ptr_q,         rd_ptr_d;
    logic [CNT_WIDTH-1:0]   fill_count_q,     fill_count_d;
    logic                   out_valid_q,      out_valid_d;
    logic                   fine_scrittura_q, fine_scrittura_d;
    logic                   fine_lettura_q,   fine_lettura_d;
    logic [DATA_WIDTH-1:0]  out_data_q;

    logic                   wr_en;
    logic                   rd_load;
    logic [ADDR_WIDTH-1:0]  rd_addr;

    assign rd_addr = rd_ptr_q[ADDR_WIDTH-1:0];

    // -------------------------------------------------------------------------
    // Next-state and datapath control
    // -------------------------------------------------------------------------
    always_comb begin
        state_d          = state_q;
        wr_ptr_d         = wr_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        fill_count_d     = fill_count_q;
        out_valid_d      = out_valid_q;
        fine_scrittura_d = fine_scrittura_q;
        fine_lettura_d   = fine_lettura_q;
        wr_en            = 1'b0;
        rd_load          = 1'b0;

        if (start_fill) begin
            // start_fill aborts whatever is running and takes priority over
            // start_drain. A word offered in the same cycle is dropped,
            // because the pointers are being cleared anyway.
            state_d          = ST_FILL;
            wr_ptr_d         = '0;
            rd_ptr_d         = '0;
            fill_count_d     = '0;
            out_valid_d      = 1'b0;
            fine_scrittura_d = 1'b0;
            fine_lettura_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Only start_fill leaves IDLE. There is nothing to drain yet.
                end

                ST_FILL: begin
                    if (in_valid) begin
                        wr_en        = 1'b1;
                        wr_ptr_d     = wr_ptr_q + ADDR_WIDTH'(1);
                        fill_count_d = fill_count_q + CNT_WIDTH'(1);
                        // The fill ends on in_last or on the last RAM address.
                        // Whichever comes first wins.
                        if (in_last || (wr_ptr_q == LAST_ADDR)) begin
                            state_d          = ST_FULL;
                            fine_scrittura_d = 1'b1;
                        end
                    end
                end

                ST_FULL: begin
                    if (start_drain) begin
                        state_d        = ST_DRAIN;
                        rd_ptr_d       = '0;
                        fine_lettura_d = 1'b0;
                    end
                end

                ST_DRAIN: begin
                    // rd_ptr_q is already one past the word on out_data. When
                    // rd_ptr_q equals fill_count_q, the word being presented is
                    // the last one.
                    if (out_valid_q && out_ready && (rd_ptr_q == fill_count_q)) begin
                        out_valid_d    = 1'b0;
                        fine_lettura_d = 1'b1;
                        state_d        = ST_FULL;
                    end else if ((!out_valid_q || out_ready) && (rd_ptr_q < fill_count_q)) begin
                        rd_load     = 1'b1;
                        out_valid_d = 1'b1;
                        rd_ptr_d    = rd_ptr_q + CNT_WIDTH'(1);
                    end else if (out_ready) begin
                        out_valid_d = 1'b0;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Control registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            fill_count_q     <= '0;
            out_valid_q      <= 1'b0;
            fine_scrittura_q <= 1'b0;
            fine_lettura_q   <= 1'b0;
        end else begin
            state_q          <= state_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            fill_count_q     <= fill_count_d;
            out_valid_q      <= out_valid_d;
            fine_scrittura_q <= fine_scrittura_d;
            fine_lettura_q   <= fine_lettura_d;
        end
    end

    // -------------------------------------------------------------------------
    // RAM write port
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram[wr_ptr_q] <= in_data;
        end
    end

    // -------------------------------------------------------------------------
    // RAM read port
    //
    // The read is registered inside this sequential block, not as a
    // combinational _d, so the output register maps onto the RAM's own read
    // register. It only changes on a load, which keeps out_data stable while
    // the consumer stalls.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data_q <= '0;
        end else if (rd_load) begin
            out_data_q <= ram[rd_addr];
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign in_ready       = (state_q == ST_FILL);
    assign out_valid      = out_valid_q;
    assign out_data       = out_data_q;
    assign fill_count     = fill_count_q;
    assign state          = state_q;
    assign fine_scrittura = fine_scrittura_q;
    assign fine_lettura   = fine_lettura_q;

endmodule

// File: tb/tb_memoria_buffer.sv
// -----------------------------------------------------------------------------
// tb_memoria_buffer
//
// Directed bench for memoria_buffer (DATA_WIDTH=8, DEPTH=512).
// Inputs are driven 1 time unit after the rising edge. Outputs are sampled at
// the same point. Each fill or drain operation prints one line.
// -----------------------------------------------------------------------------
module tb_memoria_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_fill;
    logic        start_drain;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic [9:0]  fill_count;
    logic [1:0]  state;
    logic        fine_scrittura;
    logic        fine_lettura;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_mem [0:511];

    memoria_buffer #(
        .DATA_WIDTH (8),
        .DEPTH      (512)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start_fill     (start_fill),
        .start_drain    (start_drain),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_last        (in_last),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_ready      (out_ready),
        .fill_count     (fill_count),
        .state          (state),
        .fine_scrittura (fine_scrittura),
        .fine_lettura   (fine_lettura)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Fill n words. mode 0: data = i mod 256; mode 1: data = 0xA0 + i.
    // start_drain is pulsed during the fill and must be ignored.
    task automatic do_fill(input int n, input bit use_last, input bit mode, input string tag);
        start_fill = 1'b1;
        @(posedge clk); #1;
        start_fill = 1'b0;
        chk({tag, "_st_fill"}, 32'(state), 32'd1);
        chk({tag, "_cnt0"}, 32'(fill_count), 32'd0);
        chk({tag, "_fs0"}, 32'(fine_scrittura), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        for (int i = 0; i < n; i++) begin
            exp_mem[i]  = mode ? 8'(160 + i) : 8'(i);
            in_valid    = 1'b1;
            in_data     = exp_mem[i];
            in_last     = use_last && (i == n - 1);
            start_drain = (i == 1);
            if (i == 2) chk({tag, "_drain_in_fill"}, 32'(state), 32'd1);
            if (i == n - 1) chk({tag, "_fs_early"}, 32'(fine_scrittura), 32'd0);
            @(posedge clk); #1;
        end
        in_valid    = 1'b0;
        in_last     = 1'b0;
        start_drain = 1'b0;
        chk({tag, "_st_full"}, 32'(state), 32'd2);
        chk({tag, "_cnt"}, 32'(fill_count), 32'(n));
        chk({tag, "_fs1"}, 32'(fine_scrittura), 32'd1);
        chk({tag, "_in_ready_off"}, 32'(in_ready), 32'd0);
        $display("fill %s: words=%0d fill_count=%0d state=%0d", tag, n, fill_count, state);
    endtask

    // Drain n words. If stall is set, out_ready follows the pattern 1,0,0,1,0,0,...
    task automatic do_drain(input int n, input bit stall, input string tag);
        int         idx;
        int         c;
        int         first_v;
        bit         held;
        logic [7:0] held_d;
        start_drain = 1'b1;
        @(posedge clk); #1;
        start_drain = 1'b0;
        chk({tag, "_st_drain"}, 32'(state), 32'd3);
        chk({tag, "_fl0"}, 32'(fine_lettura), 32'd0);
        chk({tag, "_ov0"}, 32'(out_valid), 32'd0);
        idx = 0; c = 0; first_v = -1; held = 1'b0; held_d = '0;
        while (idx < n && c < 4 * n + 20) begin
            out_ready = stall ? (c % 3 == 0) : 1'b1;
            if (held) begin
                chk({tag, "_hold_v"}, 32'(out_valid), 32'd1);
                chk({tag, "_hold_d"}, 32'(out_data), 32'(held_d));
                held = 1'b0;
            end
            if (out_valid) begin
                if (first_v < 0) first_v = c;
                if (out_ready) begin
                    chk({tag, "_word"}, 32'(out_data), 32'(exp_mem[idx]));
                    if (idx == n - 1) chk({tag, "_fl_early"}, 32'(fine_lettura), 32'd0);
                    idx++;
                end else begin
                    held   = 1'b1;
                    held_d = out_data;
                end
            end
            @(posedge clk); #1;
            c++;
        end
        out_ready = 1'b0;
        chk({tag, "_count"}, 32'(idx), 32'(n));
        chk({tag, "_latency"}, 32'(first_v), 32'd1);
        if (!stall) chk({tag, "_b2b"}, 32'(c), 32'(n + 1));
        chk({tag, "_fl1"}, 32'(fine_lettura), 32'd1);
        chk({tag, "_st_end"}, 32'(state), 32'd2);
        chk({tag, "_ov_end"}, 32'(out_valid), 32'd0);
        $display("drain %s: words=%0d cycles=%0d stall=%0d", tag, idx, c, stall);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; start_fill = 1'b0; start_drain = 1'b0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        #2;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_fill_count", 32'(fill_count), 32'd0);
        chk("rst_fs", 32'(fine_scrittura), 32'd0);
        chk("rst_fl", 32'(fine_lettura), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // start_drain in IDLE is ignored
        start_drain = 1'b1;
        @(posedge clk); #1;
        start_drain = 1'b0;
        chk("idle_drain_ignored", 32'(state), 32'd0);

        // Full-depth fill, then a drain without stalls and a drain with stalls
        do_fill(512, 1'b0, 1'b0, "fill512");
        in_valid = 1'b1; in_data = 8'hFF;
        @(posedge clk); @(posedge clk); #1;
        in_valid = 1'b0;
        chk("full_extra_write", 32'(fill_count), 32'd512);
        chk("full_extra_state", 32'(state), 32'd2);
        do_drain(512, 1'b0, "drain512");
        do_drain(512, 1'b1, "drain512_stall");

        // Short fill ended by in_last, drained twice (start_fill from FULL aborts)
        do_fill(5, 1'b1, 1'b1, "fill5");
        do_drain(5, 1'b0, "drain5_a");
        do_drain(5, 1'b1, "drain5_b");

        // Reset asserted between clock edges in the middle of a drain
        out_ready = 1'b0;
        start_drain = 1'b1;
        @(posedge clk); #1;
        start_drain = 1'b0;
        @(posedge clk); #1;
        chk("mid_ov_before", 32'(out_valid), 32'd1);
        chk("mid_data_before", 32'(out_data), 32'h0A0);
        #2;
        reset = 1'b1;
        #1;
        chk("async_ov", 32'(out_valid), 32'd0);
        chk("async_state", 32'(state), 32'd0);
        chk("async_fs", 32'(fine_scrittura), 32'd0);
        chk("async_fl", 32'(fine_lettura), 32'd0);
        chk("async_cnt", 32'(fill_count), 32'd0);
        chk("async_data", 32'(out_data), 32'd0);
        $display("reset mid-drain: state=%0d out_valid=%0d", state, out_valid);
        @(posedge clk); #1;
        reset = 1'b0;

        // start_fill (together with start_drain) while draining
        do_fill(5, 1'b1, 1'b1, "fill5_again");
        out_ready = 1'b1;
        start_drain = 1'b1;
        @(posedge clk); #1;
        start_drain = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("abort_ov_before", 32'(out_valid), 32'd1);
        start_fill = 1'b1; start_drain = 1'b1;
        @(posedge clk); #1;
        start_fill = 1'b0; start_drain = 1'b0; out_ready = 1'b0;
        chk("abort_ov", 32'(out_valid), 32'd0);
        chk("abort_cnt", 32'(fill_count), 32'd0);
        chk("abort_state", 32'(state), 32'd1);
        chk("abort_fs", 32'(fine_scrittura), 32'd0);
        chk("abort_fl", 32'(fine_lettura), 32'd0);
        $display("abort during drain: state=%0d fill_count=%0d", state, fill_count);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
